// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing the async FIFO write port
// among NUM_REQ valid/ready requesters, granting bursts of up to MAX_BURST words.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    output logic                          busy
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);
    localparam int CNT_W = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [ID_WIDTH:0] NREQ = (ID_WIDTH + 1)'(NUM_REQ);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]            state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   sel;
    logic [ID_WIDTH-1:0]   next_ptr;
    logic [CNT_W-1:0]      burst_cnt;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];
    logic                  xfer;
    logic                  done;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // first valid index at or above rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        sel = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            logic [ID_WIDTH:0] j;
            j = {1'b0, rr_ptr} + (ID_WIDTH + 1)'(k);
            j = j >= NREQ ? j - NREQ : j;
            sel = req_valid[j[ID_WIDTH-1:0]] ? j[ID_WIDTH-1:0] : sel;
        end
    end

    assign busy      = state == GRANT;
    assign xfer      = busy && req_valid[gnt_id] && !full;
    assign w_en      = xfer;
    assign data_in   = busy ? words[gnt_id] : '0;
    assign req_ready = (busy && !full) ? NUM_REQ'(1) << gnt_id : '0;
    assign next_ptr  = gnt_id == LAST_ID ? '0 : gnt_id + 1'b1;
    assign done      = !req_valid[gnt_id] || (xfer && burst_cnt == LAST_BEAT);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (|req_valid) begin
                gnt_id    <= sel;
                burst_cnt <= '0;
                state     <= GRANT;
            end
        end else begin
            burst_cnt <= xfer ? burst_cnt + 1'b1 : burst_cnt;
            if (done) begin
                state  <= IDLE;
                rr_ptr <= next_ptr;
            end
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed checks of grant order, bursts, full stalls,
// async reset, and an end-to-end run through a behavioural FIFO.
module tb_fifo_write_arbiter;
    localparam int DW = 8;
    localparam int N  = 4;

    logic          wclk = 0;
    logic          rclk = 0;
    logic          wrst = 1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic          full = 0;
    logic          w_en;
    logic [DW-1:0] data_in;
    logic [1:0]    gnt_id;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] q [N][$];
    logic [N-1:0] en = '0;
    logic [7:0] lg_d[$];
    logic [1:0] lg_g[$];
    logic [7:0] fifo[$];
    logic [7:0] rx[$];
    bit e2e = 0;

    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(4)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .full(full), .w_en(w_en), .data_in(data_in),
        .gnt_id(gnt_id), .busy(busy)
    );

    always #10 wclk = ~wclk;
    always #35 rclk = ~rclk;

    always @(posedge rclk) if (fifo.size() > 0) rx.push_back(fifo.pop_front());

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && q[i].size() > 0;
            req_data[i*DW +: DW] = q[i].size() > 0 ? q[i][0] : '0;
        end
        if (e2e) full = fifo.size() >= 8;
        #1;
    endtask

    // sample the handshake before the edge, then apply its effects after it
    task automatic tick();
        logic [N-1:0] acc;
        logic wr;
        logic [7:0] d;
        logic [1:0] g;
        acc = req_valid & req_ready;
        wr = w_en;
        d = data_in;
        g = gnt_id;
        if (wr) chk("wen_while_full", {31'b0, full}, 0);
        @(posedge wclk);
        #1;
        if (wr) begin
            lg_d.push_back(d);
            lg_g.push_back(g);
            if (e2e) fifo.push_back(d);
        end
        for (int i = 0; i < N; i++) if (acc[i]) void'(q[i].pop_front());
        drive();
    endtask

    task automatic rst_dut();
        wrst = 1;
        en = '0;
        full = 0;
        for (int i = 0; i < N; i++) q[i].delete();
        lg_d.delete();
        lg_g.delete();
        fifo.delete();
        rx.delete();
        drive();
        tick();
        #3 wrst = 0;
    endtask

    initial begin
        // reset with random activity on inputs
        for (int i = 0; i < N; i++) begin
            q[i].push_back(8'h11);
            q[i].push_back(8'h22);
        end
        en = 4'($urandom);
        full = 1'($urandom);
        drive();
        tick();
        tick();
        chk("rst_wen", {31'b0, w_en}, 0);
        chk("rst_ready", {28'b0, req_ready}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_gnt", {30'b0, gnt_id}, 0);
        chk("rst_data", {24'b0, data_in}, 0);
        en = 4'b0100;
        full = 0;
        drive();
        #3 wrst = 0;
        tick();
        chk("pre_arst_busy", {31'b0, busy}, 1);
        chk("pre_arst_wen", {31'b0, w_en}, 1);
        #5 wrst = 1;
        #1;
        chk("arst_wen", {31'b0, w_en}, 0);
        chk("arst_ready", {28'b0, req_ready}, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_gnt", {30'b0, gnt_id}, 0);
        tick();
        chk("arst_no_write", lg_d.size(), 0);
        chk("arst_no_pop", q[2].size(), 2);
        #3 wrst = 0;
        en = 4'b1111;
        drive();
        tick();
        chk("arst_prio0", {30'b0, gnt_id}, 0);

        // single requester, three words then valid drops
        rst_dut();
        q[2] = '{8'hA1, 8'hA2, 8'hA3};
        en = 4'b0100;
        drive();
        chk("t2_idle_busy", {31'b0, busy}, 0);
        chk("t2_idle_wen", {31'b0, w_en}, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("t2_gnt", {30'b0, gnt_id}, 2);
            chk("t2_wen", {31'b0, w_en}, 1);
            chk("t2_data", {24'b0, data_in}, 32'hA1 + k);
            chk("t2_ready", {28'b0, req_ready}, 4'b0100);
            tick();
        end
        chk("t2_drop_wen", {31'b0, w_en}, 0);
        chk("t2_drop_busy", {31'b0, busy}, 1);
        tick();
        chk("t2_exit_busy", {31'b0, busy}, 0);
        chk("t2_gnt_hold", {30'b0, gnt_id}, 2);
        for (int i = 0; i < N; i++) q[i].push_back(8'h5A);
        en = 4'b1111;
        drive();
        tick();
        chk("t2_next_from3", {30'b0, gnt_id}, 3);
        en = 4'b0000;
        drive();
        chk("t2_zero_word", {31'b0, w_en}, 0);
        tick();
        en = 4'b1010;
        drive();
        tick();
        chk("t2_ptr_adv", {30'b0, gnt_id}, 1);

        // all requesters continuously valid: grant order 0,1,2,3,0
        rst_dut();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) q[i].push_back(8'(i * 16 + k));
        en = 4'b1111;
        drive();
        for (int c = 0; c < 25; c++) begin
            int ph, g;
            ph = c % 5;
            g = (c / 5) % 4;
            chk("t3_busy", {31'b0, busy}, ph != 0);
            chk("t3_wen", {31'b0, w_en}, ph != 0);
            chk("t3_ready", {28'b0, req_ready}, ph != 0 ? 32'(1 << g) : 0);
            if (ph != 0) begin
                chk("t3_gnt", {30'b0, gnt_id}, g);
                chk("t3_data", {24'b0, data_in}, g * 16 + (c / 20) * 4 + ph - 1);
            end
            tick();
        end

        // full stall mid-burst
        rst_dut();
        for (int k = 0; k < 6; k++) q[1].push_back(8'h10 + 8'(k));
        en = 4'b0010;
        drive();
        tick();
        chk("t4_d0", {24'b0, data_in}, 8'h10);
        tick();
        chk("t4_d1", {24'b0, data_in}, 8'h11);
        tick();
        full = 1;
        drive();
        for (int k = 0; k < 5; k++) begin
            chk("t4_stall_wen", {31'b0, w_en}, 0);
            chk("t4_stall_ready", {28'b0, req_ready}, 0);
            chk("t4_stall_gnt", {30'b0, gnt_id}, 1);
            chk("t4_stall_busy", {31'b0, busy}, 1);
            tick();
        end
        full = 0;
        drive();
        chk("t4_d2", {24'b0, data_in}, 8'h12);
        tick();
        chk("t4_d3", {24'b0, data_in}, 8'h13);
        chk("t4_d3_wen", {31'b0, w_en}, 1);
        tick();
        chk("t4_end_busy", {31'b0, busy}, 0);
        en = 4'b0000;
        drive();
        chk("t4_count", lg_d.size(), 4);
        for (int k = 0; k < lg_d.size(); k++) chk("t4_word", {24'b0, lg_d[k]}, 32'h10 + k);
        chk("t4_left", q[1].size(), 2);

        // wrap: after grant to 2, requester 3 beats requester 1
        rst_dut();
        q[2].push_back(8'h55);
        en = 4'b0100;
        drive();
        tick();
        tick();
        tick();
        q[1].push_back(8'h66);
        q[3].push_back(8'h77);
        en = 4'b1010;
        drive();
        tick();
        chk("t5_gnt3", {30'b0, gnt_id}, 3);
        for (int k = 0; k < 5; k++) tick();
        chk("t5_count", lg_d.size(), 3);
        if (lg_d.size() == 3) begin
            chk("t5_g0", {30'b0, lg_g[0]}, 2);
            chk("t5_g1", {30'b0, lg_g[1]}, 3);
            chk("t5_g2", {30'b0, lg_g[2]}, 1);
            chk("t5_d1", {24'b0, lg_d[1]}, 8'h77);
            chk("t5_d2", {24'b0, lg_d[2]}, 8'h66);
        end

        // end to end through a depth-8 FIFO drained on rclk
        rst_dut();
        e2e = 1;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 30; k++) q[i].push_back({2'(i), 6'(k)});
        for (int t = 0; t < 3000 && rx.size() < 120; t++) begin
            en = 4'($urandom);
            drive();
            tick();
        end
        chk("e2e_count", rx.size(), 120);
        begin
            int nxt [N];
            for (int i = 0; i < N; i++) nxt[i] = 0;
            foreach (rx[k]) begin
                chk("e2e_order", {26'b0, rx[k][5:0]}, nxt[rx[k][7:6]]);
                nxt[rx[k][7:6]]++;
            end
        end
        e2e = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
